// File: rtl/mcycle_unit.sv
// Multi-cycle unsigned multiply / restoring divide engine, one bit per clock.
// Start is sampled only in IDLE; Done is a registered one-cycle pulse and Busy stalls the pipeline.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic               op;
    logic [WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [WIDTH:0]     sum, diff;
    logic               last;

    assign last      = (count == CW'(WIDTH - 1));
    assign Busy      = ((state == S_IDLE) && Start) || (state == S_COMPUTE);
    assign dbg_state = state;

    always_ff @(posedge CLK) begin
        if (!RESET_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (Start) state_next = S_COMPUTE;
            S_COMPUTE: if (last)  state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // acc holds {product_hi, multiplier} for multiply and {remainder, quotient} for divide;
    // addend is the multiplicand or the divisor respectively.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        diff     = acc[2*WIDTH-1:WIDTH-1] - {1'b0, addend};
        acc_next = acc;
        if (!op) begin
            if (acc[0]) acc_next = {sum, acc[WIDTH-1:1]};
            else        acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end else begin
            if (!diff[WIDTH]) acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else              acc_next = {acc[2*WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            Result1 <= '0;
            Result2 <= '0;
            Done    <= 1'b0;
            count   <= '0;
            op      <= 1'b0;
            addend  <= '0;
            acc     <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        op     <= MCycleOp;
                        addend <= MCycleOp ? Operand2 : Operand1;
                        acc    <= {{WIDTH{1'b0}}, (MCycleOp ? Operand1 : Operand2)};
                        count  <= '0;
                    end
                end
                S_COMPUTE: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (last) begin
                        Result1 <= acc_next[WIDTH-1:0];
                        Result2 <= acc_next[2*WIDTH-1:WIDTH];
                        Done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
